// File: rtl/edge_detection_pkg.sv
// Shared types and constants for the 3x3 edge-detection front end.
package edge_detection_pkg;

    localparam int unsigned H_PIXELS_C = 640;
    localparam int unsigned V_LINES_C  = 480;
    localparam int unsigned COL_W      = 10;

    typedef enum logic [1:0] {IDLE, VBLANK, ACTIVE, HBLANK} lbc_state_t;

    typedef logic [1:0]       buf_sel_t;
    typedef logic [COL_W-1:0] col_t;

    typedef struct packed {
        logic de;
        logic hsync;
        logic vsync;
    } sync_bus_t;

    localparam sync_bus_t SYNC_IDLE = '{de: 1'b0, hsync: 1'b1, vsync: 1'b1};

    // Buffer rotation 0 -> 1 -> 2 -> 0.
    function automatic buf_sel_t next_buf(input buf_sel_t s);
        return (s == buf_sel_t'(2)) ? buf_sel_t'(0) : buf_sel_t'(s + buf_sel_t'(1));
    endfunction

endpackage

// File: rtl/video_sync_delay.sv
// Fixed-depth delay line for DE/HSYNC/VSYNC, filled with idle levels on reset.
module video_sync_delay
    import edge_detection_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  sync_bus_t sync_i,
    output sync_bus_t sync_o
);

    sync_bus_t pipe_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= SYNC_IDLE;
            end
        end else begin
            pipe_q[0] <= sync_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign sync_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/line_buffer_ctrl.sv
// Sequences the three rotating line buffers behind the 3x3 window and
// re-times the video syncs to the filter datapath latency.
module line_buffer_ctrl
    import edge_detection_pkg::*;
#(
    parameter int unsigned H_PIXELS = H_PIXELS_C,
    parameter int unsigned V_LINES  = V_LINES_C,
    parameter int unsigned PIPE_LAT = 4
) (
    input  logic       I_PCLK,
    input  logic       I_RST_N,
    input  logic       I_DE,
    input  logic       I_HSYNC,
    input  logic       I_VSYNC,
    output logic       O_WR_EN,
    output logic [1:0] O_WR_SEL,
    output logic [9:0] O_ADDR,
    output logic [1:0] O_TOP_SEL,
    output logic       O_WIN_VALID,
    output logic       O_FRAME_START,
    output logic       O_ERR,
    output logic       O_DE,
    output logic       O_HSYNC,
    output logic       O_VSYNC
);

    // Pixel and line counters reach H_PIXELS / V_LINES so a full line or frame is distinguishable.
    localparam int unsigned CNT_W = $clog2(H_PIXELS + 1);
    localparam int unsigned ROW_W = $clog2(V_LINES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(H_PIXELS);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(V_LINES);

    lbc_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ROW_W-1:0] row_q, row_d;
    buf_sel_t         sel_q, sel_d;

    logic     wr_en_q, wr_en_d;
    buf_sel_t wr_sel_q, wr_sel_d;
    col_t     addr_q, addr_d;
    buf_sel_t top_sel_q, top_sel_d;
    logic     win_valid_q, win_valid_d;
    logic     frame_start_q, frame_start_d;
    logic     err_q, err_d;
    logic     pix_c;

    always_ff @(posedge I_PCLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // VSYNC wins over DE; pixels are only accepted once a frame start has been seen.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        row_d         = row_q;
        sel_d         = sel_q;
        wr_en_d       = 1'b0;
        wr_sel_d      = wr_sel_q;
        addr_d        = addr_q;
        top_sel_d     = top_sel_q;
        win_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        err_d         = err_q;
        pix_c         = 1'b0;

        case (state_q)
            IDLE: begin
                if (!I_VSYNC) state_d = VBLANK;
            end
            VBLANK: begin
                if (I_VSYNC && I_DE) begin
                    state_d       = ACTIVE;
                    frame_start_d = 1'b1;
                    err_d         = 1'b0;
                    pix_c         = 1'b1;
                end
            end
            ACTIVE: begin
                if (!I_VSYNC) begin
                    state_d = VBLANK;
                    err_d   = 1'b1;
                end else if (I_DE) begin
                    pix_c = 1'b1;
                end else begin
                    state_d = HBLANK;
                    if (cnt_q != CNT_MAX) err_d = 1'b1;
                    cnt_d = '0;
                    if (row_q != ROW_MAX) row_d = row_q + ROW_W'(1);
                    sel_d = next_buf(sel_q);
                end
            end
            HBLANK: begin
                if (!I_VSYNC) begin
                    state_d = VBLANK;
                end else if (I_DE) begin
                    state_d = ACTIVE;
                    pix_c   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pix_c) begin
            wr_sel_d  = sel_q;
            top_sel_d = next_buf(sel_q);
            addr_d    = (cnt_q >= CNT_MAX) ? col_t'(CNT_MAX - CNT_W'(1)) : col_t'(cnt_q);
            if ((cnt_q >= CNT_MAX) || (row_q >= ROW_MAX)) begin
                err_d = 1'b1;
            end else begin
                wr_en_d     = 1'b1;
                win_valid_d = (row_q >= ROW_W'(2)) && (cnt_q >= CNT_W'(2));
            end
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        end

        // Counters are clean whenever a frame is about to start.
        if (state_d == VBLANK) begin
            cnt_d = '0;
            row_d = '0;
            sel_d = '0;
        end
    end

    always_ff @(posedge I_PCLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            cnt_q         <= '0;
            row_q         <= '0;
            sel_q         <= '0;
            wr_en_q       <= 1'b0;
            wr_sel_q      <= '0;
            addr_q        <= '0;
            top_sel_q     <= buf_sel_t'(1);
            win_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            row_q         <= row_d;
            sel_q         <= sel_d;
            wr_en_q       <= wr_en_d;
            wr_sel_q      <= wr_sel_d;
            addr_q        <= addr_d;
            top_sel_q     <= top_sel_d;
            win_valid_q   <= win_valid_d;
            frame_start_q <= frame_start_d;
            err_q         <= err_d;
        end
    end

    assign O_WR_EN       = wr_en_q;
    assign O_WR_SEL      = wr_sel_q;
    assign O_ADDR        = addr_q;
    assign O_TOP_SEL     = top_sel_q;
    assign O_WIN_VALID   = win_valid_q;
    assign O_FRAME_START = frame_start_q;
    assign O_ERR         = err_q;

    sync_bus_t sync_in, sync_out;

    assign sync_in = '{de: I_DE, hsync: I_HSYNC, vsync: I_VSYNC};

    video_sync_delay #(
        .DEPTH (PIPE_LAT)
    ) u_sync_delay (
        .clk    (I_PCLK),
        .rst_n  (I_RST_N),
        .sync_i (sync_in),
        .sync_o (sync_out)
    );

    assign O_DE    = sync_out.de;
    assign O_HSYNC = sync_out.hsync;
    assign O_VSYNC = sync_out.vsync;

endmodule
